mbist_march_engine: RTL and testbench
=====================================

Name: mbist_march_engine

Overview:
- Parametrised memory BIST controller; successor to the fixed 4-bit-address controller.
- Runs a selectable March algorithm (March C- or MATS+) with a selectable data background (solid or checkerboard) against one external synchronous single-port RAM of configurable address and data width.
- Reports done/pass, the first failing address and a saturating fail count.
- Sits between the top-level test_mode control and the RAM's BIST-side mux.

Parameters:
AWIDTH, 4, address width; N = 2**AWIDTH words
DWIDTH, 8, data width (>=2)
CWIDTH, 8, fail counter width

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-low reset
test_mode  in  1  level: 1 = run/hold BIST, 0 = idle/abort
alg_sel  in  1  0 = March C-, 1 = MATS+; sampled when leaving IDLE
bg_sel  in  1  0 = solid, 1 = checkerboard; sampled when leaving IDLE
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable (valid with mem_en)
mem_addr  out  AWIDTH  RAM address
mem_wdata  out  DWIDTH  RAM write data
mem_rdata  in  DWIDTH  RAM read data, valid 1 cycle after read issue
bist_done  out  1  run complete
bist_status  out  1  1 = pass; valid only while bist_done=1
fail_addr  out  AWIDTH  address of first miscompare
fail_count  out  CWIDTH  number of miscompared reads, saturating

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; all outputs 0. Reset overrides everything, including mid-run.
- States:
  - IDLE -> RUN when test_mode=1; latches alg_sel/bg_sel; clears fail_addr, fail_count and the fail flag.
  - RUN issues one RAM op per cycle.
  - RUN -> DRAIN after the last op.
  - DRAIN (1 cycle) compares the final read.
  - DRAIN -> DONE.
  - DONE holds results while test_mode=1; DONE -> IDLE when test_mode=0.
  - RUN/DRAIN -> IDLE immediately when test_mode=0 (abort): mem_en=0 next cycle, bist_done stays 0, fail registers keep their partial values until the next start.
- March C- elements (element index E):
  - E0 any(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 any(r0)
  - Total OPS = 10N. "any" elements run up.
- MATS+ elements:
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 down(r1,w0)
  - Total OPS = 5N.
- Sequencing: ops within an element are applied to one address before advancing; up = 0..N-1, down = N-1..0; address wraps to the start value at each element boundary.
- Data background: logical 0 maps to all-zeros when bg_sel=0. When bg_sel=1 it maps to {DWIDTH/2{2'b01}} at even addresses and its bitwise inverse at odd addresses. Logical 1 is always the bitwise inverse of logical 0.
- Timing:
  - Edge 0 samples test_mode=1 in IDLE.
  - Op k (1-based) drives mem_en/we/addr/wdata during cycle k.
  - A read issued in cycle k is compared in cycle k+1 against a registered expected value.
  - bist_done and bist_status update on edge OPS+2.
- Miscompare:
  - fail_count increments by 1 per failing read and saturates at 2**CWIDTH-1.
  - fail_addr is written on the first miscompare only.
  - bist_status = (fail_count==0) at done.
- mem_en=0 in IDLE, DRAIN and DONE; mem_we=0 whenever mem_en=0; mem_wdata=0 on read cycles.
- test_mode held high through DONE does not restart; a new run needs test_mode low for at least 1 cycle.

Test Plan:
- Defaults, fault-free RAM model, alg_sel=0, bg_sel=0, test_mode 0->1 -> exactly 160 mem_en cycles; bist_done=1 on edge 162; bist_status=1, fail_count=0.
- alg_sel=1, bg_sel=1, fault-free -> 80 ops; done on edge 82; pass. Writes in E0 to addr 2 = 8'h55 and to addr 3 = 8'hAA.
- March C-, bg_sel=0, addr 3 bit0 stuck-at-0 -> bist_status=0, fail_addr=3, fail_count=2 (failures in E2 and E4).
- March C-, bg_sel=1, same stuck-at fault -> fail_addr=3, fail_count=2. Then a second fault, addr 9 bit7 stuck-at-1 -> fail_addr=3 (first fault is kept), fail_count=4.
- CWIDTH=2, every read corrupted -> fail_count saturates at 3, fail_addr=0, bist_status=0.
- test_mode dropped in cycle 50 of a March C- run -> mem_en=0 from cycle 51, bist_done never rises. Restart after 1 low cycle -> full clean run, done on edge 162. Separately, rst=0 mid-run -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/mbist_march_engine.sv
// March C- / MATS+ memory BIST sequencer for one synchronous single-port RAM.
// Issues one RAM op per cycle and tracks pass/fail, first failing address and a saturating fail count.
module mbist_march_engine #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              test_mode,
    input  logic              alg_sel,
    input  logic              bg_sel,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              bist_done,
    output logic              bist_status,
    output logic [AWIDTH-1:0] fail_addr,
    output logic [CWIDTH-1:0] fail_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [AWIDTH-1:0] ADDR_MAX = '1;
    localparam logic [CWIDTH-1:0] CNT_MAX  = '1;

    state_t            state;
    state_t            state_nxt;
    logic              alg_q;
    logic              bg_q;
    logic [2:0]        elem;
    logic              op_idx;
    logic [AWIDTH-1:0] addr;
    logic              rd_pending;
    logic [DWIDTH-1:0] exp_data;
    logic [AWIDTH-1:0] rd_addr;
    logic              fail_flag;

    logic [2:0]        elem_last;
    logic              two_ops;
    logic              elem_down;
    logic              next_down;
    logic              op_rd;
    logic              op_val;
    logic              at_end;
    logic              op_last;
    logic              last_op;
    logic              miscompare;
    logic [DWIDTH-1:0] cur_data;

    // Logical-0 pattern: zeros, or 0101.. at even / 1010.. at odd addresses.
    function automatic logic [DWIDTH-1:0] bg_word(input logic bg, input logic [AWIDTH-1:0] a);
        logic [DWIDTH-1:0] w;
        w = '0;
        if (bg) begin
            for (int i = 0; i < 2 * (DWIDTH / 2); i++) begin
                w[i] = ~i[0];
            end
            if (a[0]) begin
                w = ~w;
            end
        end
        return w;
    endfunction

    // Both algorithms share the op pattern: first op reads (except E0), second op writes the inverse.
    always_comb begin
        elem_last = alg_q ? 3'd2 : 3'd5;
        if (alg_q) begin
            two_ops   = (elem == 3'd1) || (elem == 3'd2);
            elem_down = (elem == 3'd2);
            next_down = (elem == 3'd1);
        end else begin
            two_ops   = (elem >= 3'd1) && (elem <= 3'd4);
            elem_down = (elem == 3'd3) || (elem == 3'd4);
            next_down = (elem == 3'd2) || (elem == 3'd3);
        end
        op_rd      = !op_idx && (elem != 3'd0);
        op_val     = op_idx ? elem[0] : ((elem != 3'd0) && !elem[0]);
        at_end     = elem_down ? (addr == '0) : (addr == ADDR_MAX);
        op_last    = !two_ops || op_idx;
        last_op    = op_last && at_end && (elem == elem_last);
        cur_data   = bg_word(bg_q, addr) ^ {DWIDTH{op_val}};
        miscompare = rd_pending && (mem_rdata != exp_data);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (test_mode) state_nxt = RUN;
            RUN:     if (!test_mode) state_nxt = IDLE;
                     else if (last_op) state_nxt = DRAIN;
            DRAIN:   state_nxt = test_mode ? DONE : IDLE;
            DONE:    if (!test_mode) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = (state == RUN);
        mem_we    = (state == RUN) && !op_rd;
        mem_addr  = (state == RUN) ? addr : '0;
        mem_wdata = ((state == RUN) && !op_rd) ? cur_data : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            alg_q       <= 1'b0;
            bg_q        <= 1'b0;
            elem        <= 3'd0;
            op_idx      <= 1'b0;
            addr        <= '0;
            rd_pending  <= 1'b0;
            exp_data    <= '0;
            rd_addr     <= '0;
            fail_flag   <= 1'b0;
            fail_addr   <= '0;
            fail_count  <= '0;
            bist_done   <= 1'b0;
            bist_status <= 1'b0;
        end else begin
            // A read is compared the cycle after issue; aborted reads are dropped.
            rd_pending <= (state == RUN) && test_mode && op_rd;
            exp_data   <= cur_data;
            rd_addr    <= addr;
            if (miscompare) begin
                if (fail_count != CNT_MAX) begin
                    fail_count <= fail_count + 1'b1;
                end
                if (!fail_flag) begin
                    fail_flag <= 1'b1;
                    fail_addr <= rd_addr;
                end
            end
            if ((state == IDLE) && test_mode) begin
                alg_q      <= alg_sel;
                bg_q       <= bg_sel;
                elem       <= 3'd0;
                op_idx     <= 1'b0;
                addr       <= '0;
                fail_flag  <= 1'b0;
                fail_addr  <= '0;
                fail_count <= '0;
            end else if (state == RUN) begin
                if (!op_last) begin
                    op_idx <= 1'b1;
                end else begin
                    op_idx <= 1'b0;
                    if (at_end) begin
                        elem <= elem + 3'd1;
                        addr <= next_down ? ADDR_MAX : '0;
                    end else begin
                        addr <= elem_down ? addr - 1'b1 : addr + 1'b1;
                    end
                end
            end
            bist_done   <= (state == DONE) && test_mode;
            bist_status <= (state == DONE) && test_mode && (fail_count == '0);
        end
    end

endmodule

// File: tb/tb_mbist_march_engine.sv
// Bench for mbist_march_engine: behavioural RAMs with injectable stuck-at faults,
// directed runs whose end results are queued and checked when bist_done rises.
`timescale 1ns/1ps
module tb_mbist_march_engine;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int CW2   = 2;
    localparam int EXP_W = 32 + 1 + AW + CW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, test_mode, alg_sel, bg_sel;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          bist_done, bist_status;
    logic [AW-1:0] fail_addr;
    logic [CW-1:0] fail_count;

    logic           test_mode2, alg_sel2, bg_sel2;
    logic           mem_en2, mem_we2;
    logic [AW-1:0]  mem_addr2;
    logic [DW-1:0]  mem_wdata2, mem_rdata2;
    logic           bist_done2, bist_status2;
    logic [AW-1:0]  fail_addr2;
    logic [CW2-1:0] fail_count2;

    mbist_march_engine #(.AWIDTH(AW), .DWIDTH(DW), .CWIDTH(CW)) dut (
        .clk(clk), .rst(rst), .test_mode(test_mode), .alg_sel(alg_sel), .bg_sel(bg_sel),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .bist_done(bist_done), .bist_status(bist_status),
        .fail_addr(fail_addr), .fail_count(fail_count)
    );

    mbist_march_engine #(.AWIDTH(AW), .DWIDTH(DW), .CWIDTH(CW2)) dut2 (
        .clk(clk), .rst(rst), .test_mode(test_mode2), .alg_sel(alg_sel2), .bg_sel(bg_sel2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .bist_done(bist_done2), .bist_status(bist_status2),
        .fail_addr(fail_addr2), .fail_count(fail_count2)
    );

    // RAM models: dut gets optional stuck-at bits on read, dut2 gets every read inverted.
    logic [DW-1:0] ram  [2**AW];
    logic [DW-1:0] ram2 [2**AW];
    logic [AW-1:0] sa0_addr = '0, sa1_addr = '0;
    logic [DW-1:0] sa0_mask = '0, sa1_mask = '0;

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            ram[i]  = '0;
            ram2[i] = '0;
        end
        mem_rdata  = '0;
        mem_rdata2 = '0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= (ram[mem_addr] & ~((mem_addr == sa0_addr) ? sa0_mask : '0))
                           | ((mem_addr == sa1_addr) ? sa1_mask : '0);
            end
        end
        if (mem_en2) begin
            if (mem_we2) ram2[mem_addr2] <= mem_wdata2;
            else         mem_rdata2 <= ~ram2[mem_addr2];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard queues: run results for dut and dut2, and E0 writes {addr,data}.
    logic [EXP_W-1:0]      exp_q[$];
    logic [1+AW+CW2-1:0]   exp2_q[$];
    logic [AW+DW-1:0]      wr_q[$];

    int   start_cyc = 0;
    int   en_cnt    = 0;
    logic done_q    = 1'b0;
    logic done2_q   = 1'b0;

    function automatic logic [EXP_W-1:0] mk_exp(input int done_e, input int n_en, input logic st,
                                                input logic [AW-1:0] fa, input logic [CW-1:0] fc);
        return {16'(done_e), 16'(n_en), st, fa, fc};
    endfunction

    always @(negedge clk) begin
        logic [EXP_W-1:0]    e;
        logic [1+AW+CW2-1:0] e2;
        logic [AW+DW-1:0]    w;
        if (mem_en) en_cnt++;
        if (mem_en && mem_we && wr_q.size() > 0) begin
            w = wr_q.pop_front();
            check("e0_write_addr", 32'(mem_addr), 32'(w[AW+DW-1 -: AW]));
            check("e0_write_data", 32'(mem_wdata), 32'(w[DW-1:0]));
        end
        if (bist_done && !done_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(bist_done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_edge", 32'(cyc - start_cyc), 32'(e[EXP_W-1 -: 16]));
                check("mem_en_cycles", 32'(en_cnt), 32'(e[EXP_W-17 -: 16]));
                check("bist_status", 32'(bist_status), 32'(e[AW+CW]));
                check("fail_addr", 32'(fail_addr), 32'(e[AW+CW-1 -: AW]));
                check("fail_count", 32'(fail_count), 32'(e[CW-1:0]));
            end
        end
        done_q = bist_done;
        if (bist_done2 && !done2_q) begin
            if (exp2_q.size() == 0) begin
                check("unexpected_done2", 32'(bist_done2), 32'd0);
            end else begin
                e2 = exp2_q.pop_front();
                check("sat_status", 32'(bist_status2), 32'(e2[AW+CW2]));
                check("sat_fail_addr", 32'(fail_addr2), 32'(e2[AW+CW2-1 -: AW]));
                check("sat_fail_count", 32'(fail_count2), 32'(e2[CW2-1:0]));
            end
        end
        done2_q = bist_done2;
    end

    task automatic start_run(input logic alg, input logic bg);
        alg_sel   = alg;
        bg_sel    = bg;
        test_mode = 1'b1;
        start_cyc = cyc + 1;
        en_cnt    = 0;
    endtask

    task automatic wait_done(input logic which, input int budget);
        int k = 0;
        while (((which ? bist_done2 : bist_done) !== 1'b1) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(which ? "done2_seen" : "done_seen", 32'(which ? bist_done2 : bist_done), 32'd1);
    endtask

    task automatic end_run();
        @(negedge clk);
        test_mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_bist_done"}, 32'(bist_done), 32'd0);
        check({tag, "_bist_status"}, 32'(bist_status), 32'd0);
        check({tag, "_fail_addr"}, 32'(fail_addr), 32'd0);
        check({tag, "_fail_count"}, 32'(fail_count), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold_en;
        rst = 1'b0; test_mode = 1'b0; alg_sel = 1'b0; bg_sel = 1'b0;
        test_mode2 = 1'b0; alg_sel2 = 1'b0; bg_sel2 = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // March C-, solid background, fault-free.
        @(negedge clk);
        exp_q.push_back(mk_exp(162, 160, 1'b1, 4'd0, 8'd0));
        start_run(1'b0, 1'b0);
        wait_done(1'b0, 400);
        end_run();

        // MATS+, checkerboard: E0 writes 55 at even, AA at odd addresses.
        for (int a = 0; a < 2**AW; a++) begin
            wr_q.push_back({4'(a), (a % 2 == 0) ? 8'h55 : 8'hAA});
        end
        exp_q.push_back(mk_exp(82, 80, 1'b1, 4'd0, 8'd0));
        start_run(1'b1, 1'b1);
        wait_done(1'b0, 400);
        hold_en = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_en) hold_en++;
        end
        check("hold_no_restart", 32'(hold_en), 32'd0);
        check("hold_done_kept", 32'(bist_done), 32'd1);
        end_run();

        // Address 3 bit 0 stuck-at-0: fails on the r1 reads of E2 and E4.
        sa0_addr = 4'd3; sa0_mask = 8'h01;
        exp_q.push_back(mk_exp(162, 160, 1'b0, 4'd3, 8'd2));
        start_run(1'b0, 1'b0);
        wait_done(1'b0, 400);
        end_run();

        exp_q.push_back(mk_exp(162, 160, 1'b0, 4'd3, 8'd2));
        start_run(1'b0, 1'b1);
        wait_done(1'b0, 400);
        end_run();

        // Add address 9 bit 7 stuck-at-1; first failing address stays 3.
        sa1_addr = 4'd9; sa1_mask = 8'h80;
        exp_q.push_back(mk_exp(162, 160, 1'b0, 4'd3, 8'd4));
        start_run(1'b0, 1'b1);
        wait_done(1'b0, 400);
        end_run();

        // Abort in cycle 50, restart after one low cycle.
        sa0_mask = '0; sa1_mask = '0;
        start_run(1'b0, 1'b0);
        repeat (50) @(negedge clk);
        test_mode = 1'b0;
        @(negedge clk);
        check("abort_mem_en", 32'(mem_en), 32'd0);
        check("abort_en_count", 32'(en_cnt), 32'd50);
        check("abort_done", 32'(bist_done), 32'd0);
        exp_q.push_back(mk_exp(162, 160, 1'b1, 4'd0, 8'd0));
        start_run(1'b0, 1'b0);
        wait_done(1'b0, 400);
        end_run();

        // Reset in the middle of a failing run.
        sa0_addr = 4'd3; sa0_mask = 8'h01;
        start_run(1'b0, 1'b0);
        repeat (70) @(negedge clk);
        check("mid_fail_count", 32'(fail_count), 32'd1);
        check("mid_fail_addr", 32'(fail_addr), 32'd3);
        rst = 1'b0;
        test_mode = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst = 1'b1;
        sa0_mask = '0;
        @(negedge clk);

        // Every read corrupted with a 2-bit counter: saturates at 3.
        exp2_q.push_back({1'b0, 4'd0, 2'd3});
        test_mode2 = 1'b1;
        wait_done(1'b1, 400);
        @(negedge clk);
        test_mode2 = 1'b0;
        repeat (2) @(negedge clk);

        check("queues_drained", 32'(exp_q.size() + exp2_q.size() + wr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
